// File: rtl/id_issue_stage_if.sv
// rtl/id_issue_stage_if.sv - fetch, writeback and EX bundle signals of the decode/issue stage
interface id_issue_stage_if #(
    parameter int XLEN = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     instr;
    logic            wb_we;
    logic [2:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_ready;
    logic            ex_valid;
    logic [3:0]      ex_opcode;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [2:0]      ex_rd;
    logic            ex_reg_we;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [XLEN-1:0] ex_store_data;
    logic            illegal;

    // The issue stage itself: consumes fetch/writeback, produces the EX bundle.
    modport master (
        input  in_valid, instr, wb_we, wb_rd, wb_data, flush, out_ready,
        output in_ready, ex_valid, ex_opcode, ex_a, ex_b, ex_rd, ex_reg_we,
               ex_mem_read, ex_mem_write, ex_store_data, illegal
    );

    // The surrounding pipeline: fetch, writeback and EX.
    modport slave (
        output in_valid, instr, wb_we, wb_rd, wb_data, flush, out_ready,
        input  in_ready, ex_valid, ex_opcode, ex_a, ex_b, ex_rd, ex_reg_we,
               ex_mem_read, ex_mem_write, ex_store_data, illegal
    );
endinterface

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - decode/issue stage with register file, scoreboard and ID/EX register
module id_issue_stage #(
    parameter int NREG = 8,
    parameter int XLEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_issue_stage_if.master bus
);
    logic [XLEN-1:0] r_rf [NREG];
    logic [NREG-1:0] r_pending;
    logic            r_ex_valid;
    logic [3:0]      r_ex_opcode;
    logic [XLEN-1:0] r_ex_a;
    logic [XLEN-1:0] r_ex_b;
    logic [2:0]      r_ex_rd;
    logic            r_ex_reg_we;
    logic            r_ex_mem_read;
    logic            r_ex_mem_write;
    logic [XLEN-1:0] r_ex_store_data;
    logic            r_illegal;

    logic [3:0]      w_op;
    logic [2:0]      w_rd;
    logic [2:0]      w_rs1;
    logic [2:0]      w_rs2;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_rd_val;
    logic [NREG-1:0] w_wb_clr;
    logic [NREG-1:0] w_pend_eff;
    logic [NREG-1:0] w_pend_next;

    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_b;
    logic            w_we_raw;
    logic            w_reg_we;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_use_rs2;
    logic            w_use_rd;
    logic            w_bubble;
    logic            w_illegal;
    logic            w_hazard;
    logic            w_adv;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_issue;

    assign w_op  = bus.instr[15:12];
    assign w_rd  = bus.instr[11:9];
    assign w_rs1 = bus.instr[8:6];
    assign w_rs2 = bus.instr[5:3];
    assign w_imm = {{(XLEN-6){bus.instr[5]}}, bus.instr[5:0]};

    // Register reads: r0 is hard zero, a same-cycle writeback is forwarded.
    assign w_rs1_val = (w_rs1 == 3'd0) ? '0 :
                       (bus.wb_we && bus.wb_rd == w_rs1) ? bus.wb_data : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 3'd0) ? '0 :
                       (bus.wb_we && bus.wb_rd == w_rs2) ? bus.wb_data : r_rf[w_rs2];
    assign w_rd_val  = (w_rd == 3'd0) ? '0 :
                       (bus.wb_we && bus.wb_rd == w_rd) ? bus.wb_data : r_rf[w_rd];

    // A register being written back this cycle no longer blocks anything.
    assign w_wb_clr   = bus.wb_we ? (NREG'(1) << bus.wb_rd) : '0;
    assign w_pend_eff = r_pending & ~w_wb_clr;

    // Instruction decode into ALU opcode, operand B source and control bits.
    always_comb begin
        w_alu_op    = 4'h0;
        w_b         = w_imm;
        w_we_raw    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_use_rs2   = 1'b0;
        w_use_rd    = 1'b0;
        w_bubble    = 1'b0;
        w_illegal   = 1'b0;
        if (!w_op[3]) begin
            w_alu_op  = w_op;
            w_b       = w_rs2_val;
            w_we_raw  = 1'b1;
            w_use_rs2 = 1'b1;
        end else begin
            case (w_op)
                4'h8: w_we_raw = 1'b1;
                4'h9: begin
                    w_alu_op = 4'h9;
                    w_b      = '0;
                    w_we_raw = 1'b1;
                end
                4'hA: begin
                    w_mem_read = 1'b1;
                    w_we_raw   = 1'b1;
                end
                4'hB: begin
                    w_mem_write = 1'b1;
                    w_use_rd    = 1'b1;
                end
                4'hF:    w_bubble = 1'b1;
                default: begin
                    w_bubble  = 1'b1;
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_reg_we = w_we_raw && (w_rd != 3'd0);

    // RAW on sources, WAW on the destination; bubbles read nothing.
    assign w_hazard = !w_bubble &&
                      (w_pend_eff[w_rs1] ||
                       (w_use_rs2 && w_pend_eff[w_rs2]) ||
                       ((w_use_rd || w_reg_we) && w_pend_eff[w_rd]));

    assign w_adv      = !r_ex_valid || bus.out_ready;
    assign w_in_ready = w_adv && !w_hazard && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_issue    = w_accept && !w_bubble;

    // Scoreboard update: writeback and flush clear first, a new issue sets last.
    always_comb begin
        w_pend_next = w_pend_eff;
        if (bus.flush && r_ex_valid && r_ex_reg_we)
            w_pend_next[r_ex_rd] = 1'b0;
        if (w_issue && w_reg_we)
            w_pend_next[w_rd] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_pend_next;
    end

    // Register file write port; r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != 3'd0) begin
            r_rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // ID/EX output register: flush drops, advance loads issue or bubble, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_opcode     <= '0;
            r_ex_a          <= '0;
            r_ex_b          <= '0;
            r_ex_rd         <= '0;
            r_ex_reg_we     <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_store_data <= '0;
            r_illegal       <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_illegal;
            if (bus.flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_adv) begin
                r_ex_valid      <= w_issue;
                r_ex_opcode     <= w_alu_op;
                r_ex_a          <= w_rs1_val;
                r_ex_b          <= w_b;
                r_ex_rd         <= w_rd;
                r_ex_reg_we     <= w_reg_we;
                r_ex_mem_read   <= w_mem_read;
                r_ex_mem_write  <= w_mem_write;
                r_ex_store_data <= w_rd_val;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_opcode     = r_ex_opcode;
    assign bus.ex_a          = r_ex_a;
    assign bus.ex_b          = r_ex_b;
    assign bus.ex_rd         = r_ex_rd;
    assign bus.ex_reg_we     = r_ex_reg_we;
    assign bus.ex_mem_read   = r_ex_mem_read;
    assign bus.ex_mem_write  = r_ex_mem_write;
    assign bus.ex_store_data = r_ex_store_data;
    assign bus.illegal       = r_illegal;
endmodule
